// File: rtl/decode_stage.sv
// Registered, handshaked RV32I decode stage with load-use hazard detection and stall counting.
// Optional M-extension decode is enabled by defining DECODE_MEXT_EN.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  input  logic             hz_load_valid,
  input  logic [4:0]       hz_load_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic             out_s_pc,
  output logic             out_s_imm,
  output logic             out_s_jalr,
  output logic             out_s_jump,
  output logic             out_s_branch,
  output logic             out_s_branch_zero,
  output logic             out_s_load,
  output logic             out_s_store,
  output logic             out_s_muldiv,
  output logic [2:0]       out_md_op,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_CMP = 4'd3, ALU_UCMP = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111, OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011, OPC_OP_IMM = 7'b0010011, OPC_OP     = 7'b0110011,
    OPC_MISC   = 7'b0001111, OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       s_pc, s_imm, s_jalr, s_jump, s_branch, s_branch_zero, s_load, s_store;
    logic       s_muldiv;
    logic [2:0] md_op;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    ctrl_t           ctrl;
    logic            illegal;
  } bundle_t;

  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_CMP;
      3'b011:  return ALU_UCMP;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  bundle_t     d, q;
  logic        valid, bad, hz;
  logic [31:0] imm_raw;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];

  always_comb begin
    d            = '0;
    d.pc         = in_pc;
    d.funct3     = f3;
    d.ctrl       = '0;
    d.ctrl.alu_op = ALU_ADD;
    imm_raw      = '0;
    bad          = 1'b0;
    case (in_inst[6:0])
      OPC_LUI: begin
        d.rd = in_inst[11:7]; imm_raw = {in_inst[31:12], 12'b0}; d.ctrl.s_imm = 1'b1;
      end
      OPC_AUIPC: begin
        d.rd = in_inst[11:7]; imm_raw = {in_inst[31:12], 12'b0};
        d.ctrl.s_pc = 1'b1; d.ctrl.s_imm = 1'b1;
      end
      OPC_JAL: begin
        d.rd = in_inst[11:7];
        imm_raw = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        d.ctrl.s_pc = 1'b1; d.ctrl.s_imm = 1'b1; d.ctrl.s_jump = 1'b1;
      end
      OPC_JALR: begin
        d.rd = in_inst[11:7]; d.rs1 = in_inst[19:15];
        imm_raw = {{20{in_inst[31]}}, in_inst[31:20]};
        d.ctrl.s_imm = 1'b1; d.ctrl.s_jalr = 1'b1; d.ctrl.s_jump = 1'b1;
        bad = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        d.rs1 = in_inst[19:15]; d.rs2 = in_inst[24:20];
        imm_raw = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        d.ctrl.s_branch = 1'b1;
        // Taken-on-zero for BEQ/BGE/BGEU: XOR/compare result of zero means the condition holds.
        d.ctrl.s_branch_zero = f3[0] ^ ~f3[2];
        case (f3[2:1])
          2'b00:   d.ctrl.alu_op = ALU_XOR;
          2'b10:   d.ctrl.alu_op = ALU_CMP;
          2'b11:   d.ctrl.alu_op = ALU_UCMP;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.rd = in_inst[11:7]; d.rs1 = in_inst[19:15];
        imm_raw = {{20{in_inst[31]}}, in_inst[31:20]};
        d.ctrl.s_imm = 1'b1; d.ctrl.s_load = 1'b1;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        d.rs1 = in_inst[19:15]; d.rs2 = in_inst[24:20];
        imm_raw = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        d.ctrl.s_imm = 1'b1; d.ctrl.s_store = 1'b1;
        bad = (f3 > 3'b010);
      end
      OPC_OP_IMM: begin
        d.rd = in_inst[11:7]; d.rs1 = in_inst[19:15];
        imm_raw = {{20{in_inst[31]}}, in_inst[31:20]};
        d.ctrl.s_imm = 1'b1;
        d.ctrl.alu_op = alu_sel(f3, (f3 == 3'b101) && in_inst[30]);
        if (f3 == 3'b001) bad = (f7 != 7'b0000000);
        if (f3 == 3'b101) bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OPC_OP: begin
        d.rd = in_inst[11:7]; d.rs1 = in_inst[19:15]; d.rs2 = in_inst[24:20];
        d.ctrl.alu_op = alu_sel(f3, in_inst[30]);
`ifdef DECODE_MEXT_EN
        if (f7 == 7'b0000001) begin
          d.ctrl.alu_op   = ALU_ADD;
          d.ctrl.s_muldiv = 1'b1;
          d.ctrl.md_op    = f3;
        end else
`endif
        if (f7 == 7'b0100000) bad = (f3 != 3'b000) && (f3 != 3'b101);
        else                  bad = (f7 != 7'b0000000);
      end
      OPC_MISC, OPC_SYSTEM: begin
        d.rd = in_inst[11:7]; d.rs1 = in_inst[19:15];
        imm_raw = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      default: bad = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) bad = 1'b1;
    d.imm = XLEN'($signed(imm_raw));
    if (bad) d.ctrl = '0;
    d.illegal = bad;
  end

  assign hz = hz_load_valid && (hz_load_rd != 5'd0) &&
              ((hz_load_rd == d.rs1) || (hz_load_rd == d.rs2));
  assign in_ready = !rst && !hz && (!valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      valid     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (in_valid && in_ready) begin
        q     <= d;
        valid <= 1'b1;
      end else if (out_ready || !valid) begin
        valid <= 1'b0;
      end
      if (!flush && in_valid && hz) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid         = valid;
  assign out_pc            = q.pc;
  assign out_rd            = q.rd;
  assign out_rs1           = q.rs1;
  assign out_rs2           = q.rs2;
  assign out_funct3        = q.funct3;
  assign out_imm           = q.imm;
  assign out_alu_op        = q.ctrl.alu_op;
  assign out_s_pc          = q.ctrl.s_pc;
  assign out_s_imm         = q.ctrl.s_imm;
  assign out_s_jalr        = q.ctrl.s_jalr;
  assign out_s_jump        = q.ctrl.s_jump;
  assign out_s_branch      = q.ctrl.s_branch;
  assign out_s_branch_zero = q.ctrl.s_branch_zero;
  assign out_s_load        = q.ctrl.s_load;
  assign out_s_store       = q.ctrl.s_store;
  assign out_s_muldiv      = q.ctrl.s_muldiv;
  assign out_md_op         = q.ctrl.md_op;
  assign out_illegal       = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles queue up on acceptance and are
// compared whenever the stage presents a valid output.
module tb_decode_stage;

  localparam logic [3:0] A_ADD = 4'd0, A_XOR = 4'd5;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [7:0]  s;    // {pc, imm, jalr, jump, branch, branch_zero, load, store}
    logic        muldiv;
    logic [2:0]  md_op;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, hz_load_valid, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm, stall_cnt;
  logic [4:0]  hz_load_rd, out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_md_op;
  logic [3:0]  out_alu_op;
  logic        out_s_pc, out_s_imm, out_s_jalr, out_s_jump, out_s_branch, out_s_branch_zero;
  logic        out_s_load, out_s_store, out_s_muldiv, out_illegal;

  int unsigned n_pass = 0, n_total = 0;
  exp_t        sb[$];
  exp_t        cur, obs;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .hz_load_valid(hz_load_valid), .hz_load_rd(hz_load_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_s_pc(out_s_pc), .out_s_imm(out_s_imm),
    .out_s_jalr(out_s_jalr), .out_s_jump(out_s_jump), .out_s_branch(out_s_branch),
    .out_s_branch_zero(out_s_branch_zero), .out_s_load(out_s_load), .out_s_store(out_s_store),
    .out_s_muldiv(out_s_muldiv), .out_md_op(out_md_op), .out_illegal(out_illegal),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd, rs1, rs2,
                              input logic [2:0] f3, input logic [31:0] imm,
                              input logic [3:0] alu, input logic [7:0] s,
                              input logic muldiv, input logic [2:0] md_op, input logic ill);
    exp_t e;
    e = '{pc, rd, rs1, rs2, f3, imm, alu, s, muldiv, md_op, ill};
    return e;
  endfunction

  // Scoreboard compare at negedge, then advance to just after the next posedge.
  task automatic tick();
    @(negedge clk);
    if (out_valid === 1'b1) begin
      obs = {out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_imm, out_alu_op,
             out_s_pc, out_s_imm, out_s_jalr, out_s_jump, out_s_branch, out_s_branch_zero,
             out_s_load, out_s_store, out_s_muldiv, out_md_op, out_illegal};
      if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        chk("bundle", obs, sb[0]);
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (in_valid && in_ready && !flush) sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; cur = e;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0;
    hz_load_valid = 1'b0; hz_load_rd = '0; out_ready = 1'b1; cur = '0;

    tick();
    chk("in_ready_in_rst", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // ADDI x1,x0,5
    drive(32'h00500093, 32'h100, mk(32'h100, 1, 0, 0, 0, 5, A_ADD, 8'b0100_0000, 0, 0, 0));
    tick();

    // Load-use hazard on x2 for ADD x3,x2,x2
    hz_load_valid = 1'b1; hz_load_rd = 5'd2;
    drive(32'h002101B3, 32'h104, mk(32'h104, 3, 2, 2, 0, 0, A_ADD, 8'b0, 0, 0, 0));
    #1;
    chk("hz_in_ready_0", in_ready, 0);
    tick();
    chk("hz_bubble", out_valid, 0);
    chk("hz_stall_1", stall_cnt, 1);
    chk("hz_in_ready_1", in_ready, 0);
    tick();
    chk("hz_stall_2", stall_cnt, 2);
    hz_load_valid = 1'b0;
    #1;
    chk("hz_release_ready", in_ready, 1);
    tick();

    // BEQ x1,x2,+8 then back-pressure with LUI x5,0x12345 waiting
    drive(32'h00208463, 32'h108, mk(32'h108, 0, 1, 2, 0, 8, A_XOR, 8'b0000_1100, 0, 0, 0));
    tick();
    out_ready = 1'b0;
    drive(32'h123452B7, 32'h10C, mk(32'h10C, 5, 0, 0, 5, 32'h12345000, A_ADD, 8'b0100_0000, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();

    // All-zero word: illegal, still delivered
    drive(32'h00000000, 32'h110, mk(32'h110, 0, 0, 0, 0, 0, 4'd0, 8'b0, 0, 0, 1));
    tick();

    // MUL x3,x1,x2
`ifdef DECODE_MEXT_EN
    drive(32'h022081B3, 32'h114, mk(32'h114, 3, 1, 2, 0, 0, 4'd0, 8'b0, 1, 0, 0));
`else
    drive(32'h022081B3, 32'h114, mk(32'h114, 3, 1, 2, 0, 0, 4'd0, 8'b0, 0, 0, 1));
`endif
    tick();

    // SW x2,0(x1) killed by flush
    flush = 1'b1;
    drive(32'h0020A023, 32'h118, '0);
    tick();
    chk("flush_out_valid", out_valid, 0);
    flush = 1'b0;

    // JAL x1,+16 ; SW x2,0(x1) ; ADDI x1,x0,-1
    drive(32'h010000EF, 32'h11C, mk(32'h11C, 1, 0, 0, 0, 16, A_ADD, 8'b1101_0000, 0, 0, 0));
    tick();
    drive(32'h0020A023, 32'h120, mk(32'h120, 0, 1, 2, 2, 0, A_ADD, 8'b0100_0001, 0, 0, 0));
    tick();
    drive(32'hFFF00093, 32'h124, mk(32'h124, 1, 0, 0, 0, 32'hFFFFFFFF, A_ADD, 8'b0100_0000, 0, 0, 0));
    tick();

    // Flush during a hazard must not count a stall cycle
    flush = 1'b1; hz_load_valid = 1'b1; hz_load_rd = 5'd2;
    drive(32'h002101B3, 32'h128, '0);
    tick();
    chk("flush_no_stall", stall_cnt, 2);
    flush = 1'b0; hz_load_valid = 1'b0; in_valid = 1'b0;

    for (int i = 0; i < 3; i++) tick();
    chk("drain_queue_empty", sb.size(), 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
